// File: rtl/dmem_access_rv_if.sv
// Signal bundle between the write-back/decoder side, dmem_access_rv and the word-wide data-memory bus.
// The unit uses the slave modport; whatever drives requests and models memory uses master.
interface dmem_access_rv_if;
    logic        iwReq;
    logic [31:0] iwAddr;
    logic        iwWrite;
    logic        iwSignExtend;
    logic [1:0]  iwAccess;
    logic [31:0] iwWData;
    logic        owBusy;
    logic        orDone;
    logic [31:0] orRData;
    logic [3:0]  orException;
    logic        orMemReq;
    logic        orMemWe;
    logic [31:0] orMemAddr;
    logic [31:0] orMemWData;
    logic [31:0] iwMemRData;
    logic        iwMemAck;

    modport slave (
        input  iwReq, iwAddr, iwWrite, iwSignExtend, iwAccess, iwWData,
        input  iwMemRData, iwMemAck,
        output owBusy, orDone, orRData, orException,
        output orMemReq, orMemWe, orMemAddr, orMemWData
    );

    modport master (
        output iwReq, iwAddr, iwWrite, iwSignExtend, iwAccess, iwWData,
        output iwMemRData, iwMemAck,
        input  owBusy, orDone, orRData, orException,
        input  orMemReq, orMemWe, orMemAddr, orMemWData
    );
endinterface

// File: rtl/dmem_access_rv.sv
// RV32 data-memory access unit: aligned/extended loads, word stores, and sub-word stores by
// read-modify-write on a bus without byte enables, with alignment checks and a per-phase bus timeout.
module dmem_access_rv #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic             iwClk,
    input logic             iwRst,
    dmem_access_rv_if.slave bus
);
    localparam logic [1:0] MEM_ACCESS_BYTE      = 2'd0;
    localparam logic [1:0] MEM_ACCESS_HALF_WORD = 2'd1;
    localparam logic [1:0] MEM_ACCESS_WORD      = 2'd2;
    localparam logic [1:0] MEM_ACCESS_ILLEGAL   = 2'd3;

    localparam logic [3:0] EXCEPTION_SUCCESS           = 4'd0;
    localparam logic [3:0] EXCEPTION_ILLEGAL_INSTR     = 4'd1;
    localparam logic [3:0] EXCEPTION_MISALIGNED_ACCESS = 4'd2;
    localparam logic [3:0] EXCEPTION_BUS_TIMEOUT       = 4'd3;

    localparam logic [7:0] TIMEOUT_LIMIT = TIMEOUT_CYCLES[7:0];

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_RMW_RD,
        S_RMW_WR,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        write_q, write_d;
    logic        sext_q, sext_d;
    logic [1:0]  access_q, access_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] merged_q, merged_d;
    logic [31:0] rdata_q, rdata_d;
    logic [3:0]  exc_q, exc_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        hold_q, hold_d;

    logic [4:0]  lane_shift;
    logic [31:0] shifted;
    logic [31:0] load_value;
    logic [31:0] lane_mask;
    logic [31:0] lane_data;
    logic [31:0] merged_word;
    logic        timed_out;
    logic        req_misaligned;

    // Lane extraction for loads and lane replacement for sub-word stores, both relative to the
    // registered address; alignment has already been guaranteed by the time a bus phase runs.
    always_comb begin
        lane_shift = {addr_q[1:0], 3'b000};
        shifted    = bus.iwMemRData >> lane_shift;
        load_value = bus.iwMemRData;
        lane_mask  = 32'h0000_FFFF << lane_shift;
        lane_data  = {2{wdata_q[15:0]}};
        case (access_q)
            MEM_ACCESS_BYTE: begin
                load_value = {{24{sext_q & shifted[7]}}, shifted[7:0]};
                lane_mask  = 32'h0000_00FF << lane_shift;
                lane_data  = {4{wdata_q[7:0]}};
            end
            MEM_ACCESS_HALF_WORD: begin
                load_value = {{16{sext_q & shifted[15]}}, shifted[15:0]};
            end
            default: begin
                load_value = bus.iwMemRData;
            end
        endcase
        merged_word = (bus.iwMemRData & ~lane_mask) | (lane_data & lane_mask);
        timed_out   = !bus.iwMemAck && (cnt_q == TIMEOUT_LIMIT);
        req_misaligned = ((bus.iwAccess == MEM_ACCESS_HALF_WORD) && bus.iwAddr[0]) ||
                         ((bus.iwAccess == MEM_ACCESS_WORD) && (bus.iwAddr[1:0] != 2'b00));
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        write_d  = write_q;
        sext_d   = sext_q;
        access_d = access_q;
        wdata_d  = wdata_q;
        merged_d = merged_q;
        rdata_d  = rdata_q;
        exc_d    = exc_q;
        cnt_d    = cnt_q;
        hold_d   = hold_q;
        case (state_q)
            S_IDLE: begin
                if (bus.iwReq) begin
                    addr_d   = bus.iwAddr;
                    write_d  = bus.iwWrite;
                    sext_d   = bus.iwSignExtend;
                    access_d = bus.iwAccess;
                    wdata_d  = bus.iwWData;
                    rdata_d  = 32'h0;
                    exc_d    = EXCEPTION_SUCCESS;
                    cnt_d    = 8'd0;
                    hold_d   = 1'b0;
                    // Rejected requests linger one extra cycle in DONE so their completion
                    // lines up with a zero-wait load.
                    if (bus.iwAccess == MEM_ACCESS_ILLEGAL) begin
                        exc_d   = EXCEPTION_ILLEGAL_INSTR;
                        hold_d  = 1'b1;
                        state_d = S_DONE;
                    end else if (req_misaligned) begin
                        exc_d   = EXCEPTION_MISALIGNED_ACCESS;
                        hold_d  = 1'b1;
                        state_d = S_DONE;
                    end else if (!bus.iwWrite) begin
                        state_d = S_RD;
                    end else if (bus.iwAccess == MEM_ACCESS_WORD) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RMW_RD;
                    end
                end
            end
            S_RD: begin
                if (bus.iwMemAck) begin
                    rdata_d = load_value;
                    state_d = S_DONE;
                end else if (timed_out) begin
                    exc_d   = EXCEPTION_BUS_TIMEOUT;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RMW_RD: begin
                if (bus.iwMemAck) begin
                    merged_d = merged_word;
                    cnt_d    = 8'd0;
                    state_d  = S_RMW_WR;
                end else if (timed_out) begin
                    exc_d   = EXCEPTION_BUS_TIMEOUT;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_WR, S_RMW_WR: begin
                if (bus.iwMemAck) begin
                    state_d = S_DONE;
                end else if (timed_out) begin
                    exc_d   = EXCEPTION_BUS_TIMEOUT;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                if (hold_q) begin
                    hold_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge iwClk) begin
        if (iwRst) begin
            state_q  <= S_IDLE;
            addr_q   <= 32'h0;
            write_q  <= 1'b0;
            sext_q   <= 1'b0;
            access_q <= 2'b00;
            wdata_q  <= 32'h0;
            merged_q <= 32'h0;
            rdata_q  <= 32'h0;
            exc_q    <= EXCEPTION_SUCCESS;
            cnt_q    <= 8'd0;
            hold_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            sext_q   <= sext_d;
            access_q <= access_d;
            wdata_q  <= wdata_d;
            merged_q <= merged_d;
            rdata_q  <= rdata_d;
            exc_q    <= exc_d;
            cnt_q    <= cnt_d;
            hold_q   <= hold_d;
        end
    end

    // Bus and handshake outputs are pure decodes of registered state.
    assign bus.owBusy      = (state_q != S_IDLE);
    assign bus.orDone      = (state_q == S_DONE) && !hold_q;
    assign bus.orRData     = rdata_q;
    assign bus.orException = exc_q;
    assign bus.orMemReq    = (state_q == S_RD) || (state_q == S_WR) ||
                             (state_q == S_RMW_RD) || (state_q == S_RMW_WR);
    assign bus.orMemWe     = (state_q == S_WR) || (state_q == S_RMW_WR);
    assign bus.orMemAddr   = {addr_q[31:2], 2'b00};
    assign bus.orMemWData  = (state_q == S_WR)     ? wdata_q  :
                             (state_q == S_RMW_WR) ? merged_q : 32'h0;

    logic unused_write;
    assign unused_write = write_q;
endmodule

// File: tb/tb_dmem_access_rv.sv
// Directed bench for dmem_access_rv: a small bus responder model plus a scoreboard of expected
// completions, checked with immediate assertions when orDone appears.
module tb_dmem_access_rv;
    localparam int TIMEOUT_CYCLES = 4;
    localparam logic [1:0] ACC_B = 2'd0;
    localparam logic [1:0] ACC_H = 2'd1;
    localparam logic [1:0] ACC_W = 2'd2;
    localparam logic [1:0] ACC_X = 2'd3;
    localparam logic [3:0] EXC_OK      = 4'd0;
    localparam logic [3:0] EXC_ILLEGAL = 4'd1;
    localparam logic [3:0] EXC_MISAL   = 4'd2;
    localparam logic [3:0] EXC_TIMEOUT = 4'd3;

    logic iwClk = 1'b0;
    logic iwRst = 1'b1;

    dmem_access_rv_if dif();

    dmem_access_rv #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
        .iwClk(iwClk),
        .iwRst(iwRst),
        .bus  (dif)
    );

    always #5 iwClk = ~iwClk;

    typedef struct {
        logic [31:0] rdata;
        bit          checkRdata;
        logic [3:0]  exc;
        int          latency;
        string       tag;
    } expect_t;

    expect_t expQ[$];
    int checks = 0;
    int failures = 0;

    logic [31:0] memWord = 32'h0;
    int          ackDelay = 0;
    bit          ackNever = 1'b0;
    int          waitCnt = 0;
    int          reqCycles = 0;
    int          writeCount = 0;
    int          weCount = 0;
    logic [7:0]  weLog = 8'h0;
    logic [31:0] lastWriteData = 32'h0;
    logic [31:0] lastAddr = 32'h0;

    // Memory responder: one ack per phase after ackDelay idle cycles, or none at all.
    always @(negedge iwClk) begin
        if (dif.orMemReq === 1'b1) begin
            reqCycles++;
            if (!ackNever && waitCnt == ackDelay) begin
                lastAddr = dif.orMemAddr;
                weLog    = {weLog[6:0], dif.orMemWe};
                weCount++;
                if (dif.orMemWe) begin
                    memWord       = dif.orMemWData;
                    lastWriteData = dif.orMemWData;
                    writeCount++;
                end
                dif.iwMemRData = memWord;
                dif.iwMemAck   = 1'b1;
                waitCnt = 0;
            end else begin
                dif.iwMemAck = 1'b0;
                waitCnt++;
            end
        end else begin
            dif.iwMemAck = 1'b0;
            waitCnt = 0;
        end
    end

    task automatic check32(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic pushExpect(input logic [31:0] rdata, input bit checkRdata, input logic [3:0] exc,
                              input int latency, input string tag);
        expect_t e;
        e.rdata = rdata;
        e.checkRdata = checkRdata;
        e.exc = exc;
        e.latency = latency;
        e.tag = tag;
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input bit write, input bit sext, input logic [1:0] access,
                                 input logic [31:0] addr, input logic [31:0] wdata, input bit holdReq);
        reqCycles  = 0;
        writeCount = 0;
        weCount    = 0;
        weLog      = 8'h0;
        dif.iwWrite      = write;
        dif.iwSignExtend = sext;
        dif.iwAccess     = access;
        dif.iwAddr       = addr;
        dif.iwWData      = wdata;
        dif.iwReq        = 1'b1;
        @(posedge iwClk);
        #1;
        if (!holdReq) dif.iwReq = 1'b0;
    endtask

    // Waits for the next completion, pops its expectation, and returns one cycle later in IDLE.
    task automatic checkOutput(input int budget);
        int cycles = 0;
        bit done = 1'b0;
        bit seenBusy = 1'b0;
        bit busyDropped = 1'b0;
        expect_t e;
        while (!done && cycles < budget) begin
            @(negedge iwClk);
            cycles++;
            if (dif.orDone === 1'b1) done = 1'b1;
            else if (dif.owBusy === 1'b1) seenBusy = 1'b1;
            else if (seenBusy) busyDropped = 1'b1;
        end
        if (expQ.size() == 0) begin
            checks++;
            failures++;
            $error("[TB] FAIL scoreboard_empty: observed 0 entries expected at least 1");
            return;
        end
        e = expQ.pop_front();
        checks++;
        assert (done) else begin
            failures++;
            $error("[TB] FAIL %s_done: observed no orDone within %0d cycles expected a pulse", e.tag, budget);
        end
        if (done) begin
            check32($sformatf("%s_latency", e.tag), 32'(cycles), 32'(e.latency));
            check32($sformatf("%s_exception", e.tag), 32'(dif.orException), 32'(e.exc));
            if (e.checkRdata) check32($sformatf("%s_rdata", e.tag), dif.orRData, e.rdata);
            check32($sformatf("%s_busy_held", e.tag), 32'(busyDropped), 32'd0);
            @(negedge iwClk);
            check32($sformatf("%s_done_pulse", e.tag), 32'(dif.orDone), 32'd0);
            if (e.checkRdata) check32($sformatf("%s_rdata_held", e.tag), dif.orRData, e.rdata);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed no end of test expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit sawDone;
        dif.iwReq        = 1'b0;
        dif.iwAddr       = 32'h0;
        dif.iwWrite      = 1'b0;
        dif.iwSignExtend = 1'b0;
        dif.iwAccess     = ACC_W;
        dif.iwWData      = 32'h0;
        dif.iwMemRData   = 32'h0;
        dif.iwMemAck     = 1'b0;

        iwRst = 1'b1;
        repeat (2) @(posedge iwClk);
        @(negedge iwClk);
        check32("reset_busy",      32'(dif.owBusy), 32'd0);
        check32("reset_done",      32'(dif.orDone), 32'd0);
        check32("reset_rdata",     dif.orRData, 32'h0);
        check32("reset_exception", 32'(dif.orException), 32'd0);
        check32("reset_memreq",    32'(dif.orMemReq), 32'd0);
        check32("reset_memwe",     32'(dif.orMemWe), 32'd0);
        check32("reset_memaddr",   dif.orMemAddr, 32'h0);
        check32("reset_memwdata",  dif.orMemWData, 32'h0);
        iwRst = 1'b0;
        @(negedge iwClk);

        // Loads from 0x80AB_CD12
        memWord = 32'h80AB_CD12;
        ackDelay = 0;
        pushExpect(32'hFFFF_FF80, 1, EXC_OK, 2, "lb_103");
        applyStimulus(0, 1, ACC_B, 32'h103, 32'h0, 0);
        checkOutput(20);
        check32("lb_103_memaddr", lastAddr, 32'h100);
        check32("lb_103_reqcycles", 32'(reqCycles), 32'd1);

        pushExpect(32'h0000_0080, 1, EXC_OK, 2, "lbu_103");
        applyStimulus(0, 0, ACC_B, 32'h103, 32'h0, 0);
        checkOutput(20);

        pushExpect(32'hFFFF_FFCD, 1, EXC_OK, 2, "lb_101");
        applyStimulus(0, 1, ACC_B, 32'h101, 32'h0, 0);
        checkOutput(20);

        pushExpect(32'hFFFF_80AB, 1, EXC_OK, 2, "lh_102");
        applyStimulus(0, 1, ACC_H, 32'h102, 32'h0, 0);
        checkOutput(20);

        ackDelay = 1;
        pushExpect(32'h0000_80AB, 1, EXC_OK, 3, "lhu_102_wait1");
        applyStimulus(0, 0, ACC_H, 32'h102, 32'h0, 0);
        checkOutput(20);
        ackDelay = 0;

        pushExpect(32'h0000_CD12, 1, EXC_OK, 2, "lhu_100");
        applyStimulus(0, 0, ACC_H, 32'h100, 32'h0, 0);
        checkOutput(20);

        pushExpect(32'h80AB_CD12, 1, EXC_OK, 2, "lw_100_sext");
        applyStimulus(0, 1, ACC_W, 32'h100, 32'h0, 0);
        checkOutput(20);

        // Stores
        memWord = 32'h1122_3344;
        pushExpect(32'h0, 0, EXC_OK, 3, "sh_202");
        applyStimulus(1, 0, ACC_H, 32'h202, 32'h0000_BEEF, 0);
        checkOutput(20);
        check32("sh_202_wdata", lastWriteData, 32'hBEEF_3344);
        check32("sh_202_writes", 32'(writeCount), 32'd1);
        check32("sh_202_phases", 32'(weCount), 32'd2);
        check32("sh_202_we_order", 32'(weLog[1:0]), 32'd1);

        pushExpect(32'h0, 0, EXC_OK, 3, "sb_201");
        applyStimulus(1, 0, ACC_B, 32'h201, 32'hFFFF_FFA5, 0);
        checkOutput(20);
        check32("sb_201_wdata", lastWriteData, 32'hBEEF_A544);

        ackDelay = 2;
        pushExpect(32'h0, 0, EXC_OK, 4, "sw_204_wait2");
        applyStimulus(1, 0, ACC_W, 32'h204, 32'hDEAD_BEEF, 0);
        checkOutput(20);
        check32("sw_204_wdata", lastWriteData, 32'hDEAD_BEEF);
        check32("sw_204_phases", 32'(weCount), 32'd1);
        check32("sw_204_reqcycles", 32'(reqCycles), 32'd3);
        ackDelay = 0;

        pushExpect(32'h0, 0, EXC_OK, 3, "sb_203");
        applyStimulus(1, 0, ACC_B, 32'h203, 32'h0000_0077, 0);
        checkOutput(20);
        check32("sb_203_wdata", lastWriteData, 32'h77AD_BEEF);

        // Rejected requests
        pushExpect(32'h0, 1, EXC_MISAL, 2, "lw_305");
        applyStimulus(0, 0, ACC_W, 32'h305, 32'h0, 0);
        checkOutput(20);
        check32("lw_305_reqcycles", 32'(reqCycles), 32'd0);

        pushExpect(32'h0, 1, EXC_ILLEGAL, 2, "acc3_300");
        applyStimulus(0, 0, ACC_X, 32'h300, 32'h0, 0);
        checkOutput(20);
        check32("acc3_300_reqcycles", 32'(reqCycles), 32'd0);

        pushExpect(32'h0, 1, EXC_MISAL, 2, "lh_101");
        applyStimulus(0, 1, ACC_H, 32'h101, 32'h0, 0);
        checkOutput(20);

        pushExpect(32'h0, 1, EXC_MISAL, 2, "sw_206");
        applyStimulus(1, 0, ACC_W, 32'h206, 32'h1234_5678, 0);
        checkOutput(20);
        check32("sw_206_writes", 32'(writeCount), 32'd0);

        // Timeouts with a limit of 4
        ackNever = 1'b1;
        pushExpect(32'h0, 1, EXC_TIMEOUT, 6, "lw_400_timeout");
        applyStimulus(0, 0, ACC_W, 32'h400, 32'h0, 0);
        checkOutput(30);
        check32("lw_400_timeout_reqcycles", 32'(reqCycles), 32'd5);

        pushExpect(32'h0, 0, EXC_TIMEOUT, 6, "sb_200_timeout");
        applyStimulus(1, 0, ACC_B, 32'h200, 32'h0000_0055, 0);
        checkOutput(30);
        check32("sb_200_timeout_reqcycles", 32'(reqCycles), 32'd5);
        check32("sb_200_timeout_writes", 32'(writeCount), 32'd0);

        ackNever = 1'b0;
        ackDelay = 4;
        memWord = 32'h1234_5678;
        pushExpect(32'h1234_5678, 1, EXC_OK, 6, "lw_400_ack_at_limit");
        applyStimulus(0, 0, ACC_W, 32'h400, 32'h0, 0);
        checkOutput(30);
        check32("lw_400_ack_at_limit_reqcycles", 32'(reqCycles), 32'd5);
        ackDelay = 0;

        // Reset while waiting in the RMW read phase
        ackNever = 1'b1;
        applyStimulus(1, 0, ACC_B, 32'h200, 32'h0000_0055, 0);
        repeat (2) @(negedge iwClk);
        iwRst = 1'b1;
        @(negedge iwClk);
        check32("rst_mid_memreq", 32'(dif.orMemReq), 32'd0);
        check32("rst_mid_busy", 32'(dif.owBusy), 32'd0);
        iwRst = 1'b0;
        ackNever = 1'b0;
        sawDone = 1'b0;
        repeat (6) begin
            @(negedge iwClk);
            if (dif.orDone === 1'b1) sawDone = 1'b1;
        end
        check32("rst_mid_no_done", 32'(sawDone), 32'd0);
        check32("rst_mid_no_write", 32'(writeCount), 32'd0);

        memWord = 32'hCAFE_F00D;
        pushExpect(32'h0000_CAFE, 1, EXC_OK, 2, "lhu_202_after_rst");
        applyStimulus(0, 0, ACC_H, 32'h202, 32'h0, 0);
        checkOutput(20);

        // Back-to-back loads with iwReq held high
        memWord = 32'h0BAD_F00D;
        pushExpect(32'h0BAD_F00D, 1, EXC_OK, 2, "b2b_first");
        pushExpect(32'h0BAD_F00D, 1, EXC_OK, 2, "b2b_second");
        applyStimulus(0, 0, ACC_W, 32'h100, 32'h0, 1);
        checkOutput(20);
        checkOutput(20);
        dif.iwReq = 1'b0;
        check32("b2b_reqcycles", 32'(reqCycles), 32'd2);
        repeat (3) @(negedge iwClk);
        check32("b2b_idle_after", 32'(dif.owBusy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
